// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and MEM-stage access FSM state encoding
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_RSP  = 2'd2,
    MA_DONE = 2'd3
  } ma_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/gnt/rvalid data-memory bus between MEM stage and memory
interface mem_access_unit_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ma_timeout_ctr.sv
// rtl/ma_timeout_ctr.sv - bus transaction cycle counter with terminal-count flag
module ma_timeout_ctr
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // TIMEOUT == 0 means the bus may stall forever
  generate
    if (TIMEOUT == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      assign tc = (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: load/store word transactions on the data bus, stall and MEM/WB outputs
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_MemtoReg,
  input  logic                  i_MemWrite,
  input  logic                  i_RegWrite,
  input  logic [31:0]           i_inst,
  input  logic [DATA_W-1:0]     i_ALUOut,
  input  logic [DATA_W-1:0]     i_WriteData,
  input  logic [REG_ADDR_W-1:0] i_WriteReg,
  output logic                  o_stall,
  output logic                  o_RegWrite,
  output logic                  o_MemtoReg,
  output logic [31:0]           o_inst,
  output logic [DATA_W-1:0]     o_ALUOut,
  output logic [REG_ADDR_W-1:0] o_WriteReg,
  output logic [DATA_W-1:0]     o_ReadData,
  output logic                  o_misalign,
  output logic                  o_bus_err,
  mem_access_unit_if.master     bus
);

  ma_state_t         state;
  logic              err;
  logic [DATA_W-1:0] rdata_q;
  logic              memop;
  logic              aligned;
  logic              start;
  logic              busy;
  logic              tc;

  assign memop   = i_MemtoReg | i_MemWrite;
  assign aligned = (i_ALUOut[1:0] == 2'b00);
  assign start   = (state == MA_IDLE) & memop & aligned;
  assign busy    = (state == MA_REQ) | (state == MA_RSP);

  ma_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (busy),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= MA_IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rdata_q       <= '0;
      err           <= 1'b0;
    end else begin
      case (state)
        MA_IDLE: begin
          if (start) begin
            bus.mem_addr  <= i_ALUOut[ADDR_W-1:0];
            bus.mem_wdata <= i_WriteData;
            // a load wins when both controls are set
            bus.mem_we    <= i_MemWrite & ~i_MemtoReg;
            bus.mem_req   <= 1'b1;
            // stores must not present a previous load's data in DONE
            rdata_q       <= '0;
            state         <= MA_REQ;
          end
        end
        MA_REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= bus.mem_we ? MA_DONE : MA_RSP;
          end else if (tc) begin
            bus.mem_req <= 1'b0;
            err         <= 1'b1;
            rdata_q     <= '0;
            state       <= MA_DONE;
          end
        end
        MA_RSP: begin
          if (bus.mem_rvalid) begin
            rdata_q <= bus.mem_rdata;
            state   <= MA_DONE;
          end else if (tc) begin
            err     <= 1'b1;
            rdata_q <= '0;
            state   <= MA_DONE;
          end
        end
        MA_DONE: begin
          err   <= 1'b0;
          state <= MA_IDLE;
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

  // during reset the state reads IDLE, so the memop term must be masked
  assign o_stall    = ~rst & (start | busy);
  assign o_misalign = memop & ~aligned;
  assign o_RegWrite = i_RegWrite & ~o_stall & ~o_misalign & ~(err & i_MemtoReg);
  assign o_MemtoReg = i_MemtoReg;
  assign o_inst     = i_inst;
  assign o_ALUOut   = i_ALUOut;
  assign o_WriteReg = i_WriteReg;
  assign o_ReadData = (state == MA_DONE) ? rdata_q : '0;
  assign o_bus_err  = (state == MA_DONE) & err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  typedef struct {
    bit          ld;
    bit          st;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gw;
    int          rwt;
    logic [31:0] rdata;
    bit          rvg;
    bit          stale;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_MemtoReg, i_MemWrite, i_RegWrite;
  logic [31:0]   i_inst;
  logic [DW-1:0] i_ALUOut, i_WriteData;
  logic [4:0]    i_WriteReg;
  logic          o_stall, o_RegWrite, o_MemtoReg, o_misalign, o_bus_err;
  logic [31:0]   o_inst;
  logic [DW-1:0] o_ALUOut, o_ReadData;
  logic [4:0]    o_WriteReg;

  logic          e_stall, e_rw, e_mis, e_berr, e_req, e_we, e_m2r;
  logic [31:0]   e_rd, e_addr, e_wdata, e_inst, e_alu;
  logic [4:0]    e_wreg;
  bit            chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_MemtoReg(i_MemtoReg), .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite),
    .i_inst(i_inst), .i_ALUOut(i_ALUOut), .i_WriteData(i_WriteData), .i_WriteReg(i_WriteReg),
    .o_stall(o_stall), .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg), .o_inst(o_inst),
    .o_ALUOut(o_ALUOut), .o_WriteReg(o_WriteReg), .o_ReadData(o_ReadData),
    .o_misalign(o_misalign), .o_bus_err(o_bus_err), .bus(bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction plan from the bus rules: n = total cycles incl. DONE, r = cycles with mem_req high
  function automatic void plan(input vec_t v, output int n, output int r, output bit to, output bit mis);
    bit memop;
    memop = v.ld | v.st;
    mis   = memop && (v.addr[1:0] != 2'b00);
    to    = 1'b0;
    r     = 0;
    n     = 1;
    if (!memop || mis) return;
    if (v.gw == 0 || v.gw > TO) begin
      to = 1'b1; r = TO; n = TO + 2;
    end else if (!v.ld) begin
      r = v.gw; n = v.gw + 2;
    end else if (v.rwt == 0 || v.gw + v.rwt > TO) begin
      to = 1'b1; r = v.gw; n = TO + 2;
    end else begin
      r = v.gw; n = v.gw + v.rwt + 2;
    end
  endfunction

  function automatic vec_t mk(input bit ld, input bit st, input bit rw, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gw, input int rwt,
                              input logic [31:0] rdata, input bit rvg, input bit stale);
    vec_t v;
    v.ld = ld; v.st = st; v.rw = rw; v.addr = addr; v.wdata = wdata;
    v.gw = gw; v.rwt = rwt; v.rdata = rdata; v.rvg = rvg; v.stale = stale;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_stall",    32'(o_stall),    32'(e_stall));
      chk("o_RegWrite", 32'(o_RegWrite), 32'(e_rw));
      chk("o_misalign", 32'(o_misalign), 32'(e_mis));
      chk("o_bus_err",  32'(o_bus_err),  32'(e_berr));
      chk("mem_req",    32'(bus.mem_req), 32'(e_req));
      chk("o_ReadData", o_ReadData,      e_rd);
      chk("o_MemtoReg", 32'(o_MemtoReg), 32'(e_m2r));
      chk("o_inst",     o_inst,          e_inst);
      chk("o_ALUOut",   o_ALUOut,        e_alu);
      chk("o_WriteReg", 32'(o_WriteReg), 32'(e_wreg));
      if (e_req) begin
        chk("mem_we",    32'(bus.mem_we), 32'(e_we));
        chk("mem_addr",  bus.mem_addr,    e_addr);
        chk("mem_wdata", bus.mem_wdata,   e_wdata);
      end
    end
  end

  // Runs one instruction through MEM for at most 'stop' cycles; called #1 after a rising edge
  task automatic run_vec(input vec_t v, input int idx, input int lit_n, input int stop);
    int n, r;
    bit to, mis, last;
    plan(v, n, r, to, mis);
    chk("model_len", 32'(n), 32'(lit_n));
    i_MemtoReg  = v.ld;
    i_MemWrite  = v.st;
    i_RegWrite  = v.rw;
    i_ALUOut    = v.addr;
    i_WriteData = v.wdata;
    i_inst      = 32'h0000_0033 ^ (32'(idx) * 32'h0101_0100);
    i_WriteReg  = 5'(idx + 1);
    e_m2r = v.ld; e_inst = i_inst; e_alu = v.addr; e_wreg = i_WriteReg;
    e_we = v.st && !v.ld; e_addr = v.addr; e_wdata = v.wdata;
    for (int c = 0; c < n && c < stop; c++) begin
      bus.mem_gnt    = (v.ld || v.st) && !mis && v.gw != 0 && c == v.gw;
      bus.mem_rvalid = (v.ld && v.rwt != 0 && (c == v.gw + v.rwt || (v.rvg && c == v.gw)))
                       || (v.stale && c == 0);
      bus.mem_rdata  = (v.ld && c == v.gw + v.rwt) ? v.rdata : ~v.rdata;
      last   = (c == n - 1);
      e_stall = !last;
      e_req   = (c >= 1 && c <= r);
      e_mis   = mis;
      e_berr  = last && to;
      e_rd    = (last && v.ld && !to && !mis) ? v.rdata : 32'h0;
      e_rw    = last && v.rw && !mis && !(to && v.ld);
      chk_en  = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  vec_t vecs[$];
  int   lits[$];

  initial begin
    vecs.push_back(mk(0, 0, 1, 32'h1234_5678, 32'h0,          0, 0, 32'h0,          0, 0)); lits.push_back(1);
    vecs.push_back(mk(0, 1, 0, 32'h0000_0100, 32'hCAFE_F00D, 1, 0, 32'h0,          0, 0)); lits.push_back(3);
    vecs.push_back(mk(1, 0, 1, 32'h0000_0200, 32'h0,          3, 3, 32'h1234_5678, 0, 0)); lits.push_back(8);
    vecs.push_back(mk(1, 0, 1, 32'h0000_0203, 32'h0,          1, 1, 32'h1111_1111, 0, 0)); lits.push_back(1);
    vecs.push_back(mk(1, 0, 1, 32'h0000_0040, 32'h0,          1, 0, 32'h2222_2222, 0, 0)); lits.push_back(10);
    vecs.push_back(mk(1, 0, 1, 32'h0000_0204, 32'h0,          1, 1, 32'hDEAD_BEEF, 1, 0)); lits.push_back(4);
    vecs.push_back(mk(0, 1, 0, 32'h0000_0208, 32'h5A5A_A5A5, 8, 0, 32'h0,          0, 0)); lits.push_back(10);
    vecs.push_back(mk(1, 0, 1, 32'h0000_020C, 32'h0,          2, 6, 32'h0BAD_F00D, 0, 0)); lits.push_back(10);
    vecs.push_back(mk(0, 1, 0, 32'h0000_010C, 32'h7777_0000, 0, 0, 32'h0,          0, 0)); lits.push_back(10);
    vecs.push_back(mk(0, 1, 0, 32'h0000_0102, 32'h3333_3333, 1, 0, 32'h0,          0, 0)); lits.push_back(1);
    vecs.push_back(mk(1, 1, 1, 32'h0000_0300, 32'h4444_4444, 1, 2, 32'h600D_CAFE, 0, 0)); lits.push_back(5);
    vecs.push_back(mk(0, 0, 0, 32'h0000_0003, 32'h0,          0, 0, 32'h0,          0, 0)); lits.push_back(1);

    rst = 1'b1;
    i_MemtoReg = 1'b0; i_MemWrite = 1'b0; i_RegWrite = 1'b0;
    i_inst = '0; i_ALUOut = '0; i_WriteData = '0; i_WriteReg = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall",     32'(o_stall),       32'h0);
    chk("reset_mem_req",   32'(bus.mem_req),   32'h0);
    chk("reset_mem_we",    32'(bus.mem_we),    32'h0);
    chk("reset_mem_addr",  bus.mem_addr,       32'h0);
    chk("reset_mem_wdata", bus.mem_wdata,      32'h0);
    chk("reset_bus_err",   32'(o_bus_err),     32'h0);
    chk("reset_readdata",  o_ReadData,         32'h0);
    i_MemtoReg = 1'b1; i_ALUOut = 32'h80;
    #1;
    chk("reset_stall_memop", 32'(o_stall), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i, lits[i], 1000);

    // abort a load in RSP with an asynchronous reset, then check a clean restart
    run_vec(mk(1, 0, 1, 32'h0000_0400, 32'h0, 1, 0, 32'h9999_9999, 0, 0), 20, 10, 3);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rsp_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_rsp_stall",   32'(o_stall),     32'h0);
    chk("rst_rsp_bus_err", 32'(o_bus_err),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(mk(0, 0, 1, 32'h0000_0044, 32'h0,          0, 0, 32'h9999_9999, 0, 1), 21, 1, 1000);
    run_vec(mk(0, 1, 0, 32'h0000_0500, 32'h1357_9BDF, 2, 0, 32'h0,          0, 0), 22, 4, 1000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
